ysyx_20020207_axi_sram: RTL and testbench

YSYX_20020207_AXI_SRAM -- requirements
Module: ysyx_20020207_axi_sram

---
 rtl/ysyx_20020207_axi_pkg.sv | 15 +
 rtl/ysyx_20020207_sram_array.sv | 34 +++
 rtl/ysyx_20020207_axi_sram.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_20020207_axi_sram.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_20020207_axi_pkg.sv
// Shared response codes, FSM state encodings and address helper for the AXI4-lite SRAM.
package ysyx_20020207_axi_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
    typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

    // Word offset from the base; addresses below base wrap high and so fail the range check.
    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/ysyx_20020207_sram_array.sv
// 1R1W synchronous word array with four byte-enable lanes; a same-edge read sees old data.
module ysyx_20020207_sram_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) begin
                    mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_20020207_axi_sram.sv
// AXI4-lite SRAM responder: independent read and write FSMs with configurable wait latency.
module ysyx_20020207_axi_sram
    import ysyx_20020207_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  RdLat = RD_LAT[3:0];
    localparam logic [3:0]  WrLat = WR_LAT[3:0];

    r_state_e         r_state_q, r_state_d;
    logic [3:0]       r_cnt_q, r_cnt_d;
    logic [IdxW-1:0]  r_idx_q, r_idx_d;
    logic             r_err_q, r_err_d;

    w_state_e         w_state_q, w_state_d;
    logic [3:0]       w_cnt_q, w_cnt_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [IdxW-1:0]  w_idx_q, w_idx_d;
    logic             w_err_q, w_err_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;

    logic [31:0] ar_off, aw_off, arr_rdata;
    logic        aw_hs, w_hs, arr_re, arr_we;

    assign ar_off = word_offset(araddr, BASE_ADDR);
    assign aw_off = word_offset(awaddr, BASE_ADDR);

    assign arready = (r_state_q == RIdle);
    assign rvalid  = (r_state_q == RResp);
    assign rdata   = (rvalid && !r_err_q) ? arr_rdata : 32'h0;
    assign rresp   = (rvalid && r_err_q) ? RespSlverr : RespOkay;

    assign awready = (w_state_q == WIdle) && !aw_done_q;
    assign wready  = (w_state_q == WIdle) && !w_done_q;
    assign bvalid  = (w_state_q == WResp);
    assign bresp   = (bvalid && w_err_q) ? RespSlverr : RespOkay;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // The array read is issued in the last wait cycle so data lands on the edge rvalid rises.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        r_err_d   = r_err_q;
        arr_re    = 1'b0;
        case (r_state_q)
            RIdle: begin
                if (arvalid) begin
                    r_state_d = RWait;
                    r_cnt_d   = '0;
                    r_idx_d   = ar_off[IdxW-1:0];
                    r_err_d   = !(ar_off < DEPTH_WORDS);
                end
            end
            RWait: begin
                if (r_cnt_q == RdLat) begin
                    arr_re    = !r_err_q;
                    r_state_d = RResp;
                end else begin
                    r_cnt_d = r_cnt_q + 4'd1;
                end
            end
            RResp: begin
                if (rready) begin
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        w_idx_d   = w_idx_q;
        w_err_d   = w_err_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        arr_we    = 1'b0;
        case (w_state_q)
            WIdle: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    w_idx_d   = aw_off[IdxW-1:0];
                    w_err_d   = !(aw_off < DEPTH_WORDS);
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    w_state_d = WWait;
                    w_cnt_d   = '0;
                end
            end
            WWait: begin
                if (w_cnt_q == WrLat) begin
                    // A reset on the commit edge must leave memory untouched.
                    arr_we    = !w_err_q && !rst;
                    w_state_d = WResp;
                end else begin
                    w_cnt_d = w_cnt_q + 4'd1;
                end
            end
            WResp: begin
                if (bready) begin
                    w_state_d = WIdle;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_err_q   <= 1'b0;
            w_state_q <= WIdle;
            w_cnt_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_idx_q   <= '0;
            w_err_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_err_q   <= r_err_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            w_idx_q   <= w_idx_d;
            w_err_q   <= w_err_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
        end
    end

    ysyx_20020207_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (IdxW)
    ) u_array (
        .clk_i  (clk),
        .re_i   (arr_re),
        .raddr_i(r_idx_q),
        .rdata_o(arr_rdata),
        .we_i   (arr_we),
        .waddr_i(w_idx_q),
        .wdata_i(w_data_q),
        .wstrb_i(w_strb_q)
    );

endmodule

// File: tb/tb_ysyx_20020207_axi_sram.sv
// Scoreboard bench: drivers push expected responses, a negedge monitor pops and compares them.
module tb_ysyx_20020207_axi_sram;

    localparam logic [31:0] Base  = 32'h8000_0000;
    localparam int unsigned Depth = 1024;
    localparam int unsigned RdLat = 1;
    localparam int unsigned WrLat = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        rready = 1'b1, bready = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    ysyx_20020207_axi_sram #(
        .BASE_ADDR  (Base),
        .DEPTH_WORDS(Depth),
        .RD_LAT     (RdLat),
        .WR_LAT     (WrLat)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    r_exp_t      exp_r[$];
    logic [1:0]  exp_b[$];
    logic [31:0] ref_mem [Depth];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, r_rise = 0, b_rise = 0;
    int r_mode = 0, b_mode = 0;  // 0 held high, 1 random, 2 held low

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rready = (r_mode == 0) || (r_mode == 1 && $urandom_range(0, 2) != 0);
        bready = (b_mode == 0) || (b_mode == 1 && $urandom_range(0, 2) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: flat word array, range test and byte-lane merge in plain arithmetic.
    function automatic bit in_range(input logic [31:0] a);
        return longint'(a) >= longint'(Base) && longint'(a) < longint'(Base) + 4 * Depth;
    endfunction

    function automatic void expect_read(input logic [31:0] a);
        r_exp_t e;
        if (in_range(a)) begin
            e.data = ref_mem[(a - Base) / 4];
            e.resp = 2'b00;
        end else begin
            e.data = 32'h0;
            e.resp = 2'b10;
        end
        exp_r.push_back(e);
    endfunction

    function automatic void expect_write(input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
        int unsigned idx;
        if (in_range(a)) begin
            idx = (a - Base) / 4;
            for (int i = 0; i < 4; i++) begin
                if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
            end
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
    endfunction

    // Monitor: compare on handshakes, check holding while stalled and single-cycle pulses.
    logic        r_stall = 0, b_stall = 0, r_hs_prev = 0, b_hs_prev = 0, rv_prev = 0, bv_prev = 0;
    logic [31:0] rdata_prev = '0;
    logic [1:0]  rresp_prev = '0, bresp_prev = '0;

    always @(negedge clk) begin
        r_exp_t     e;
        logic [1:0] eb;
        if (!rst) begin
            if (r_stall) check("r_hold", {rvalid, rdata, rresp}, {1'b1, rdata_prev, rresp_prev});
            if (b_stall) check("b_hold", {bvalid, bresp}, {1'b1, bresp_prev});
            if (r_hs_prev) check("r_pulse", rvalid, 1'b0);
            if (b_hs_prev) check("b_pulse", bvalid, 1'b0);
            if (rvalid && !rv_prev) r_rise = cyc;
            if (bvalid && !bv_prev) b_rise = cyc;
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL r_unexpected: got rdata %h, required no response", rdata);
                end else begin
                    e = exp_r.pop_front();
                    check("r_data", rdata, e.data);
                    check("r_resp", rresp, e.resp);
                end
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL b_unexpected: got bresp %h, required no response", bresp);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_resp", bresp, eb);
                end
            end
        end
        r_stall    = !rst && rvalid && !rready;
        b_stall    = !rst && bvalid && !bready;
        r_hs_prev  = !rst && rvalid && rready;
        b_hs_prev  = !rst && bvalid && bready;
        rv_prev    = rvalid;
        bv_prev    = bvalid;
        rdata_prev = rdata;
        rresp_prev = rresp;
        bresp_prev = bresp;
    end

    // Drivers start and finish 1 time unit after a rising edge; hs returns the handshake edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output int hs);
        int aw_hs = -1, w_hs = -1;
        fork
            begin
                logic rdy;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awvalid = 1'b1;
                awaddr  = a;
                for (int t = 0; t < 100 && aw_hs < 0; t++) begin
                    @(negedge clk); rdy = awready;
                    @(posedge clk); #1;
                    if (rdy) aw_hs = cyc;
                end
                awvalid = 1'b0;
            end
            begin
                logic rdy;
                repeat (w_dly) begin @(posedge clk); #1; end
                wvalid = 1'b1;
                wdata  = d;
                wstrb  = s;
                for (int t = 0; t < 100 && w_hs < 0; t++) begin
                    @(negedge clk); rdy = wready;
                    @(posedge clk); #1;
                    if (rdy) w_hs = cyc;
                end
                wvalid = 1'b0;
            end
        join
        if (aw_hs < 0 || w_hs < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL aw_w_timeout: got aw %0d w %0d, required both accepted", aw_hs, w_hs);
        end
        hs = (aw_hs > w_hs) ? aw_hs : w_hs;
    endtask

    task automatic do_read(input logic [31:0] a, input int dly, output int hs);
        logic rdy;
        hs = -1;
        repeat (dly) begin @(posedge clk); #1; end
        arvalid = 1'b1;
        araddr  = a;
        for (int t = 0; t < 100 && hs < 0; t++) begin
            @(negedge clk); rdy = arready;
            @(posedge clk); #1;
            if (rdy) hs = cyc;
        end
        arvalid = 1'b0;
        if (hs < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ar_timeout: got no AR handshake, required one");
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got pending r=%0d b=%0d, required 0", exp_r.size(),
                     exp_b.size());
            exp_r.delete();
            exp_b.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        check(name, {arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp},
              {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00});
    endtask

    initial begin
        int hs, hs2, k;
        logic [31:0] a, a2, d;
        logic [3:0]  s;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            expect_write(Base + 4 * i, $urandom, 4'hF);
            do_write(Base + 4 * i, ref_mem[i], 4'hF, 0, 0, hs);
            wait_drain();
        end

        // Full write then read with latency measured from the AR handshake.
        expect_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, hs);
        wait_drain();
        check("w_latency", b_rise - hs, 1 + WrLat);
        expect_read(32'h8000_0010);
        do_read(32'h8000_0010, 0, hs);
        wait_drain();
        check("r_latency", r_rise - hs, 1 + RdLat);
        check("deadbeef_model", ref_mem[4], 32'hDEAD_BEEF);

        // Partial strobes merge into the existing word.
        expect_write(32'h8000_0020, 32'h1122_3344, 4'hF);
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, hs);
        expect_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0110);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0110, 0, 0, hs);
        wait_drain();
        expect_read(32'h8000_0020);
        do_read(32'h8000_0020, 0, hs);
        wait_drain();
        check("strobe_model", ref_mem[8], 32'h11BB_CC44);

        // W leads AW by 3 cycles and bready is withheld; bvalid must hold.
        b_mode = 2;
        expect_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF);
        do_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 3, 0, hs);
        repeat (4) begin @(posedge clk); #1; end
        check("b_held", {bvalid, bresp}, {1'b1, 2'b00});
        b_mode = 0;
        wait_drain();
        check("w_skew_latency", b_rise - hs, 1 + WrLat);
        expect_read(32'h8000_0030);
        do_read(32'h8000_0030, 0, hs);
        wait_drain();

        // Out-of-range accesses, then word 0 must be unchanged.
        expect_read(32'h7FFF_FFFC);
        do_read(32'h7FFF_FFFC, 0, hs);
        expect_write(32'h8000_1000, 32'h5555_AAAA, 4'hF);
        do_write(32'h8000_1000, 32'h5555_AAAA, 4'hF, 0, 0, hs);
        wait_drain();
        expect_read(Base);
        do_read(Base, 0, hs);
        wait_drain();

        // Read load and write commit on the same edge: old data, then new data.
        expect_read(32'h8000_0040);
        expect_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF);
        fork
            do_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF, 0, 0, hs);
            do_read(32'h8000_0040, 0, hs2);
        join
        check("collide_same_edge", hs2, hs);
        wait_drain();
        expect_read(32'h8000_0040);
        do_read(32'h8000_0040, 0, hs);
        wait_drain();

        // Reset while the write waits: no response, no memory change.
        do_write(32'h8000_0050, 32'hFFFF_0000, 4'hF, 0, 0, hs);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("reset_mid_write");
        @(posedge clk); #1;
        expect_read(32'h8000_0050);
        do_read(32'h8000_0050, 0, hs);
        wait_drain();

        // Randomized traffic with random ready back-pressure.
        r_mode = 1;
        b_mode = 1;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 31);
            a = Base + 4 * k + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? Base - 4 : $urandom;
            d = $urandom;
            s = 4'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    expect_write(a, d, s);
                    do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), hs);
                end
                1: begin
                    expect_read(a);
                    do_read(a, $urandom_range(0, 3), hs);
                end
                default: begin
                    a  = Base + 4 * k;
                    a2 = Base + 4 * ((k + 1 + $urandom_range(0, 30)) % 32);
                    expect_read(a2);
                    expect_write(a, d, s);
                    fork
                        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), hs);
                        do_read(a2, $urandom_range(0, 2), hs2);
                    join
                end
            endcase
            wait_drain();
        end
        r_mode = 0;
        b_mode = 0;
        repeat (3) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
